// File: rtl/mod_74x08_n_bist.sv
// mod_74x08_n_bist: registered N-channel 2-input gate bank (AND/NAND/OR/XOR)
// with a built-in self-test that walks every channel through its truth table.

// One gate channel: selected 2-input function, optionally inverted by INJ.
module mod_74x08_n_bist_lane (
   input  logic       a,
   input  logic       b,
   input  logic [1:0] func,
   input  logic       inj,
   output logic       y_d
);
   // Gate function followed by the fault-injection inversion.
   always_comb begin
      y_d = 1'b0;
      case (func)
         2'b00:   y_d = a & b;
         2'b01:   y_d = ~(a & b);
         2'b10:   y_d = a | b;
         default: y_d = a ^ b;
      endcase
      y_d = y_d ^ inj;
   end
endmodule

module mod_74x08_n_bist #(
   parameter int CHANNELS = 4,
   parameter int FCW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CHANNELS-1:0] A,
   input  logic [CHANNELS-1:0] B,
   input  logic [1:0]          FUNC,
   input  logic [CHANNELS-1:0] INJ,
   input  logic                BIST_START,
   output logic [CHANNELS-1:0] Y,
   output logic                BIST_BUSY,
   output logic                BIST_DONE,
   output logic                BIST_PASS,
   output logic [FCW-1:0]      BIST_FAIL_CH
);
   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   state_t              state, state_nx;
   logic [1:0]          func_q, func_q_nx;
   logic [1:0]          combo, combo_nx;
   logic [FCW-1:0]      ch, ch_nx;
   logic                pass_nx;
   logic [FCW-1:0]      fail_ch_nx;
   logic                bist_act;
   logic [CHANNELS-1:0] oh, op_a, op_b, y_d;
   logic [1:0]          op_f;
   logic                exp_bit;

   function automatic logic gate_f(input logic [1:0] f, input logic a, input logic b);
      case (f)
         2'b00:   return a & b;
         2'b01:   return ~(a & b);
         2'b10:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // Operand mux: BIST pattern on the channel under test, external pins otherwise.
   always_comb begin
      bist_act = (state == APPLY) || (state == CHECK);
      oh       = '0;
      oh[ch]   = 1'b1;
      op_a     = A;
      op_b     = B;
      op_f     = FUNC;
      if (bist_act) begin
         op_a = combo[1] ? oh : '0;
         op_b = combo[0] ? oh : '0;
         op_f = func_q;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      mod_74x08_n_bist_lane u_lane (
         .a    (op_a[i]),
         .b    (op_b[i]),
         .func (op_f),
         .inj  (INJ[i]),
         .y_d  (y_d[i])
      );
   end

   // Sequencer next-state. Only the channel under test is judged, so a fault
   // is attributed to its own channel rather than to whichever run sees it first.
   always_comb begin
      state_nx   = state;
      func_q_nx  = func_q;
      combo_nx   = combo;
      ch_nx      = ch;
      pass_nx    = BIST_PASS;
      fail_ch_nx = BIST_FAIL_CH;
      exp_bit    = gate_f(func_q, combo[1], combo[0]);
      case (state)
         IDLE: begin
            if (BIST_START) begin
               func_q_nx = FUNC;
               ch_nx     = '0;
               combo_nx  = '0;
               state_nx  = APPLY;
            end
         end
         APPLY: state_nx = CHECK;
         CHECK: begin
            if (Y[ch] != exp_bit) begin
               fail_ch_nx = ch;
               pass_nx    = 1'b0;
               state_nx   = DONE;
            end else if (combo == 2'd3) begin
               if (ch == FCW'(CHANNELS - 1)) begin
                  pass_nx    = 1'b1;
                  fail_ch_nx = '0;
                  state_nx   = DONE;
               end else begin
                  ch_nx    = ch + FCW'(1);
                  combo_nx = '0;
                  state_nx = APPLY;
               end
            end else begin
               combo_nx = combo + 2'd1;
               state_nx = APPLY;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, gate outputs and registered status decode.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= IDLE;
         func_q       <= 2'b00;
         combo        <= '0;
         ch           <= '0;
         Y            <= '0;
         BIST_BUSY    <= 1'b0;
         BIST_DONE    <= 1'b0;
         BIST_PASS    <= 1'b0;
         BIST_FAIL_CH <= '0;
      end else begin
         state        <= state_nx;
         func_q       <= func_q_nx;
         combo        <= combo_nx;
         ch           <= ch_nx;
         Y            <= y_d;
         BIST_BUSY    <= (state_nx == APPLY) || (state_nx == CHECK);
         BIST_DONE    <= (state_nx == DONE);
         BIST_PASS    <= pass_nx;
         BIST_FAIL_CH <= fail_ch_nx;
      end
   end
endmodule

// File: tb/tb_mod_74x08_n_bist.sv
// Randomised self-checking bench for mod_74x08_n_bist with CHANNELS=3.
module tb_mod_74x08_n_bist;
   localparam int N   = 3;
   localparam int FCW = 2;

   logic           CLK = 1'b0;
   logic           RST_N = 1'b0;
   logic [N-1:0]   A = '0, B = '0, INJ = '0;
   logic [1:0]     FUNC = 2'b00;
   logic           BIST_START = 1'b0;
   logic [N-1:0]   Y;
   logic           BIST_BUSY, BIST_DONE, BIST_PASS;
   logic [FCW-1:0] BIST_FAIL_CH;

   int total = 0;
   int bad   = 0;
   int prev_pass = 0;
   int prev_fch  = 0;

   mod_74x08_n_bist #(.CHANNELS(N)) dut (
      .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .FUNC(FUNC), .INJ(INJ),
      .BIST_START(BIST_START), .Y(Y), .BIST_BUSY(BIST_BUSY),
      .BIST_DONE(BIST_DONE), .BIST_PASS(BIST_PASS), .BIST_FAIL_CH(BIST_FAIL_CH)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Bank-wide gate function on whole vectors.
   function automatic logic [N-1:0] vf(input logic [1:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
      case (f)
         2'b00:   return a & b;
         2'b01:   return ~(a & b);
         2'b10:   return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // Walk the truth table: channel c sees one-hot operands per combo; an inverted
   // output on c is the only way that channel can disagree with the ideal gate.
   task automatic model_bist(input logic [1:0] f, input logic [N-1:0] inj,
                             output int pass, output int fch, output int lat);
      logic [N-1:0] oh, av, bv, ideal, seen;
      pass = 1; fch = 0; lat = 8 * N;
      for (int c = 0; c < N; c++) begin
         for (int m = 0; m < 4; m++) begin
            oh    = N'(1) << c;
            av    = (m >= 2) ? oh : '0;
            bv    = (m % 2 == 1) ? oh : '0;
            ideal = vf(f, av, bv);
            seen  = ideal ^ inj;
            if (seen[c] != ideal[c]) begin
               pass = 0; fch = c; lat = 8 * c + 2 * m + 2;
               return;
            end
         end
      end
   endtask

   task automatic run_bist(input string tag, input logic [1:0] f, input logic [N-1:0] inj, input bit noise);
      int ep, ef, el, n, busy_cnt;
      model_bist(f, inj, ep, ef, el);
      FUNC = f; INJ = inj; BIST_START = 1'b1;
      tick();
      BIST_START = 1'b0;
      chk({tag, "_pass_held"}, BIST_PASS, prev_pass);
      chk({tag, "_fch_held"}, BIST_FAIL_CH, prev_fch);
      n = 0; busy_cnt = 0;
      while (!BIST_DONE && n < 200) begin
         if (BIST_BUSY) busy_cnt++;
         if (noise) begin
            A = N'($urandom); B = N'($urandom); FUNC = 2'($urandom);
            BIST_START = 1'($urandom);
         end
         tick();
         n++;
      end
      BIST_START = 1'b0;
      chk({tag, "_lat"}, n, el);
      chk({tag, "_busy_cycles"}, busy_cnt, el);
      chk({tag, "_busy_in_done"}, BIST_BUSY, 0);
      chk({tag, "_pass"}, BIST_PASS, ep);
      chk({tag, "_fch"}, BIST_FAIL_CH, ef);
      tick();
      chk({tag, "_done_pulse"}, BIST_DONE, 0);
      tick();
      chk({tag, "_idle_busy"}, BIST_BUSY, 0);
      chk({tag, "_pass_hold"}, BIST_PASS, ep);
      prev_pass = ep; prev_fch = ef;
      INJ = '0;
   endtask

   initial begin
      logic [N-1:0] ey, hold;
      int ep, ef, el;
      // reset state
      tick(); tick();
      chk("rst_y", Y, 0);
      chk("rst_busy", BIST_BUSY, 0);
      chk("rst_done", BIST_DONE, 0);
      chk("rst_pass", BIST_PASS, 0);
      chk("rst_fch", BIST_FAIL_CH, 0);
      RST_N = 1'b1;

      // directed normal path
      FUNC = 2'b00; A = 3'b100; B = 3'b100; tick(); chk("and_100", Y, 3'b100);
      A = 3'b010; B = 3'b000; tick(); chk("and_010", Y, 3'b000);
      A = 3'b001; B = 3'b001; tick(); chk("and_001", Y, 3'b001);
      FUNC = 2'b11; A = 3'b111; B = 3'b101; tick(); chk("xor_111", Y, 3'b010);

      // random normal path, INJ included
      for (int i = 0; i < 40; i++) begin
         A = N'($urandom); B = N'($urandom); FUNC = 2'($urandom); INJ = N'($urandom);
         ey = vf(FUNC, A, B) ^ INJ;
         tick();
         chk("rand_y", Y, ey);
      end
      INJ = '0;

      // reset without an edge has no effect, with an edge clears everything
      FUNC = 2'b00; A = 3'b111; B = 3'b111; tick();
      hold = Y;
      RST_N = 1'b0; #2;
      chk("rst_noedge_y", Y, hold);
      chk("rst_noedge_nz", Y, 3'b111);
      tick(); RST_N = 1'b1;
      chk("rst_edge_y", Y, 0);
      chk("rst_edge_busy", BIST_BUSY, 0);
      prev_pass = 0; prev_fch = 0;

      // self-test: clean pass and injected fault
      run_bist("nand_pass", 2'b01, 3'b000, 1'b0);
      run_bist("or_inj1", 2'b10, 3'b010, 1'b0);

      // mid-run reset aborts without a DONE pulse
      FUNC = 2'b00; BIST_START = 1'b1; tick(); BIST_START = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy_before", BIST_BUSY, 1);
      RST_N = 1'b0; tick(); RST_N = 1'b1;
      chk("mid_busy", BIST_BUSY, 0);
      chk("mid_done", BIST_DONE, 0);
      chk("mid_pass", BIST_PASS, 0);
      chk("mid_fch", BIST_FAIL_CH, 0);
      ep = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (BIST_DONE || BIST_BUSY) ep++;
      end
      chk("mid_no_done", ep, 0);
      prev_pass = 0; prev_fch = 0;
      run_bist("post_rst", 2'b00, 3'b000, 1'b0);

      // noise on pins and START during the run
      run_bist("noise", 2'b11, 3'b000, 1'b1);
      A = '0; B = '0;

      // random runs, single or no injected fault
      for (int i = 0; i < 6; i++) begin
         el = $urandom_range(0, N);
         run_bist("rand_bist", 2'($urandom), (el == N) ? N'(0) : (N'(1) << el), 1'b1);
         A = '0; B = '0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
